// File: rtl/serial_popcount_rx.sv
// Serial-in receiver for the counting-ones datapath.
// Rebuilds a WIDTH-bit word sent LSB first and counts its ones on the fly,
// then presents word and count together with a one-cycle done pulse.
module serial_popcount_rx #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sin,
  input  logic             sin_valid,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] data_out,
  output logic [CNT_W-1:0] ones
);

  localparam int IDX_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  state_t           next_state;
  logic [WIDTH-1:0] sreg;
  logic [CNT_W-1:0] acc;
  logic [IDX_W-1:0] idx;
  logic [WIDTH-1:0] shifted;
  logic [CNT_W-1:0] acc_next;
  logic             take_bit;
  logic             last_bit;

  assign take_bit = (state == SHIFT) && sin_valid;
  assign last_bit = take_bit && (idx == IDX_W'(WIDTH - 1));
  assign shifted  = {sin, sreg[WIDTH-1:1]};
  assign acc_next = acc + CNT_W'(sin);

  // State register; reset drops any frame in flight back to IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state logic: start only counts in IDLE, DONE always lasts one cycle.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = SHIFT;
      SHIFT:   if (last_bit) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Moore outputs decoded purely from the state register.
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      SHIFT:   busy = 1'b1;
      DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  // Datapath: clear on frame start, shift/count on each valid bit, publish on the last one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg     <= '0;
      acc      <= '0;
      idx      <= '0;
      data_out <= '0;
      ones     <= '0;
    end else if (state == IDLE && start) begin
      sreg <= '0;
      acc  <= '0;
      idx  <= '0;
    end else if (take_bit) begin
      sreg <= shifted;
      acc  <= acc_next;
      idx  <= idx + 1'b1;
      if (last_bit) begin
        data_out <= shifted;
        ones     <= acc_next;
      end
    end
  end

endmodule

// File: tb/tb_serial_popcount_rx.sv
// Scoreboard bench for serial_popcount_rx: the stimulus pushes hand-computed
// word/count/done-cycle expectations, a monitor pops them on every done pulse.
module tb_serial_popcount_rx;

  localparam int WIDTH = 8;
  localparam int CNT_W = 4;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic             sin;
  logic             sin_valid;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] data_out;
  logic [CNT_W-1:0] ones;

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic [CNT_W-1:0] ones;
    int               done_cyc;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  serial_popcount_rx #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .sin       (sin),
    .sin_valid (sin_valid),
    .busy      (busy),
    .done      (done),
    .data_out  (data_out),
    .ones      (ones)
  );

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Edge counter used to time the done pulse.
  always @(posedge clk) cyc <= cyc + 1;

  // Hard stop if something hangs.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required finish before limit");
    $fatal(1, "[TB] watchdog expired");
  end

  // Compare all four visible outputs at once against constants.
  task automatic checkOutput(input string name, input logic exp_busy, input logic exp_done,
                             input logic [WIDTH-1:0] exp_data, input logic [CNT_W-1:0] exp_ones);
    checks++;
    if (busy !== exp_busy || done !== exp_done || data_out !== exp_data || ones !== exp_ones) begin
      failures++;
      $display("[TB] FAIL %s: got busy=%b done=%b data=%h ones=%0d, want busy=%b done=%b data=%h ones=%0d",
               name, busy, done, data_out, ones, exp_busy, exp_done, exp_data, exp_ones);
    end
  endtask

  // Send one frame; gaps[i] idle cycles follow bit i, start_mask[i] raises start alongside bit i.
  task automatic applyStimulus(input logic [WIDTH-1:0] word, input logic [CNT_W-1:0] exp_ones,
                               input logic [WIDTH-1:0][3:0] gaps, input logic [WIDTH-1:0] start_mask);
    int   gap_sum;
    exp_t e;
    gap_sum = 0;
    for (int i = 0; i < WIDTH; i++) gap_sum += int'(gaps[i]);
    @(negedge clk);
    start     = 1'b1;
    sin_valid = 1'b0;
    e.data     = word;
    e.ones     = exp_ones;
    e.done_cyc = cyc + 1 + WIDTH + gap_sum;
    exp_q.push_back(e);
    for (int i = 0; i < WIDTH; i++) begin
      @(negedge clk);
      start     = start_mask[i];
      sin       = word[i];
      sin_valid = 1'b1;
      for (int g = 0; g < int'(gaps[i]); g++) begin
        @(negedge clk);
        start     = 1'b0;
        sin_valid = 1'b0;
        sin       = ~sin;
      end
    end
    @(negedge clk);
    start     = 1'b0;
    sin_valid = 1'b0;
    sin       = 1'b0;
  endtask

  // Monitor: each done pulse must match the oldest expectation and last one cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && done === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_done: got done=1 data=%h ones=%0d, want no done pulse", data_out, ones);
        end else begin
          e = exp_q.pop_front();
          checks++;
          if (data_out !== e.data || ones !== e.ones || busy !== 1'b1) begin
            failures++;
            $display("[TB] FAIL frame_result: got data=%h ones=%0d busy=%b, want data=%h ones=%0d busy=1",
                     data_out, ones, busy, e.data, e.ones);
          end
          checks++;
          if (cyc != e.done_cyc) begin
            failures++;
            $display("[TB] FAIL done_latency: got done at cycle %0d, want cycle %0d", cyc, e.done_cyc);
          end
          @(negedge clk);
          checks++;
          if (done !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL done_pulse_end: got done=%b busy=%b, want done=0 busy=0", done, busy);
          end
        end
      end
    end
  end

  // Directed scenario sequence.
  initial begin
    logic [WIDTH-1:0][3:0] no_gaps;
    logic [WIDTH-1:0][3:0] gaps_5a;
    int wait_cycles;
    no_gaps = '0;
    gaps_5a = '0;
    gaps_5a[2] = 4'd3;
    gaps_5a[5] = 4'd2;

    rst_n = 1'b0;
    start = 1'b0;
    sin = 1'b0;
    sin_valid = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("reset_state", 1'b0, 1'b0, 8'h00, 4'd0);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("idle_after_reset", 1'b0, 1'b0, 8'h00, 4'd0);

    $display("[TB] frame 0xB6");
    applyStimulus(8'hB6, 4'd5, no_gaps, 8'h00);
    @(negedge clk);
    checkOutput("idle_after_b6", 1'b0, 1'b0, 8'hB6, 4'd5);

    $display("[TB] back-to-back 0x00 then 0xFF");
    applyStimulus(8'h00, 4'd0, no_gaps, 8'h00);
    applyStimulus(8'hFF, 4'd8, no_gaps, 8'h00);

    $display("[TB] gapped frame 0x5A");
    applyStimulus(8'h5A, 4'd4, gaps_5a, 8'h00);

    $display("[TB] start pulses during frame 0x81");
    applyStimulus(8'h81, 4'd2, no_gaps, 8'h88);
    repeat (3) @(negedge clk);
    checkOutput("no_restart_after_81", 1'b0, 1'b0, 8'h81, 4'd2);

    $display("[TB] reset mid-frame");
    applyStimulus(8'h3C, 4'd4, no_gaps, 8'h00);
    @(negedge clk);
    checkOutput("after_3c", 1'b0, 1'b0, 8'h3C, 4'd4);
    @(negedge clk);
    start = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      start     = 1'b0;
      sin       = (8'hF0 >> i) & 1'b1;
      sin_valid = 1'b1;
    end
    @(negedge clk);
    checkOutput("mid_frame_busy", 1'b1, 1'b0, 8'h3C, 4'd4);
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset", 1'b0, 1'b0, 8'h00, 4'd0);
    sin_valid = 1'b0;
    @(negedge clk);
    checkOutput("held_reset", 1'b0, 1'b0, 8'h00, 4'd0);
    rst_n = 1'b1;
    applyStimulus(8'h0F, 4'd4, no_gaps, 8'h00);

    $display("[TB] idle noise");
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      checkOutput("idle_noise", 1'b0, 1'b0, 8'h0F, 4'd4);
      sin       = i[0];
      sin_valid = i[1] | i[0];
      @(negedge clk);
    end
    sin = 1'b0;
    sin_valid = 1'b0;
    checkOutput("idle_noise_end", 1'b0, 1'b0, 8'h0F, 4'd4);

    wait_cycles = 0;
    while (exp_q.size() != 0 && wait_cycles < 50) begin
      @(negedge clk);
      wait_cycles++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("[TB] FAIL pending_frames: got %0d frames without done, want 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
